// File: rtl/ones_count_frame_acc.sv
// ones_count_frame_acc: sums GROUPS 2-bit ones counts per frame, then pulses done with the total.
module ones_count_frame_acc #(
  parameter int GROUPS = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             y1,
  input  logic             y0,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_out
);
  localparam int IDX_W = $clog2(GROUPS);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] acc, sum;
  logic [IDX_W-1:0] idx;
  logic accept, last;
  always_comb begin
    accept = state == ACC && in_valid;
    sum = acc + CNT_W'({y1, y0});
    last = idx == IDX_W'(GROUPS - 1);
    state_nx = state == IDLE ? (start ? ACC : IDLE) :
               state == ACC  ? (accept && last ? DONE : ACC) : IDLE;
  end
  assign in_ready = state == ACC;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      idx <= '0;
      count_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        acc <= '0;
        idx <= '0;
      end
      if (accept) begin
        acc <= sum;
        idx <= idx + 1'b1;
        if (last) count_out <= sum;
      end
    end
  end
endmodule

// File: tb/tb_ones_count_frame_acc.sv
// tb_ones_count_frame_acc: randomized + directed frames checked by a frame-level scoreboard.
module tb_ones_count_frame_acc;
  localparam int GROUPS = 8;
  localparam int CNT_W = 5;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, y1 = 0, y0 = 0;
  logic in_ready, busy, done;
  logic [CNT_W-1:0] count_out;
  int n_vec = 0, n_bad = 0;
  int m_phase = 0;
  int m_last = 0;
  int grp[$];
  int exp_q[$];

  ones_count_frame_acc #(.GROUPS(GROUPS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .y1(y1), .y0(y0),
    .in_ready(in_ready), .busy(busy), .done(done), .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input int c);
    int tot;
    @(negedge clk);
    rst = r; start = s; in_valid = v; {y1, y0} = 2'(c);
    if (r) begin
      m_phase = 0; m_last = 0; grp.delete();
    end else if (m_phase == 0) begin
      if (s) begin m_phase = 1; grp.delete(); end
    end else if (m_phase == 1) begin
      if (v) grp.push_back(c);
      if (grp.size() == GROUPS) begin
        tot = 0;
        foreach (grp[i]) tot += grp[i];
        tot = tot % (1 << CNT_W);
        exp_q.push_back(tot);
        m_last = tot;
        m_phase = 2;
      end
    end else m_phase = 0;
  endtask

  always @(posedge clk) begin
    #1;
    check("done", done, m_phase == 2);
    check("in_ready", in_ready, m_phase == 1);
    check("busy", busy, m_phase != 0);
    check("count_out", count_out, m_last);
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else check("frame_total", count_out, exp_q.pop_front());
    end
  end

  task automatic frame(input int codes[GROUPS], input int gap_after, input int gap_len);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < GROUPS; i++) begin
      cyc(0, 0, 1, codes[i]);
      if (i == gap_after) for (int g = 0; g < gap_len; g++) cyc(0, 0, 0, 3);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    int all3[GROUPS] = '{3, 3, 3, 3, 3, 3, 3, 3};
    int mix[GROUPS] = '{0, 1, 2, 3, 3, 2, 1, 0};
    int ones[GROUPS] = '{1, 1, 1, 1, 1, 1, 1, 1};
    int f10[GROUPS] = '{2, 2, 2, 1, 1, 1, 1, 0};
    int f7[GROUPS] = '{1, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 2; i++) cyc(1, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    cyc(0, 0, 0, 0);
    frame(all3, -1, 0);
    frame(mix, 2, 2);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < GROUPS; i++) begin
      cyc(0, i == 4, 1, 2);
      if (i == 3) cyc(0, 1, 0, 0);
    end
    cyc(0, 0, 1, 3);
    frame(ones, -1, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 2);
    cyc(1, 1, 1, 3);
    cyc(0, 0, 0, 0);
    frame(ones, -1, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < GROUPS; i++) cyc(0, 1, 1, f10[i]);
    cyc(0, 1, 1, 3);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < GROUPS; i++) cyc(0, 1, i != 3, f7[i]);
    cyc(0, 1, 1, f7[3]);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3));
    cyc(0, 0, 0, 0);
    for (int i = 0; i < GROUPS + 3; i++) cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
